fir_sample_queue: RTL and testbench

FIR_SAMPLE_QUEUE -- requirements
Module: fir_sample_queue

---
 rtl/fir_sample_queue_pkg.sv | 9 +
 rtl/fir_sample_queue_if.sv | 19 +
 rtl/fir_sample_queue_ram.sv | 18 +
 rtl/fir_sample_queue.sv | 73 +++++++
 tb/tb_fir_sample_queue.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_sample_queue_pkg.sv
// fir_queue_pkg: shared state encoding and default sizing for the FIR sample queue.
package fir_queue_pkg;
    typedef enum logic {FILL, SEQ} state_t;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_NCH     = 2;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_SEQ_LEN = 1021;
    localparam int DEF_DECIM   = 1;
endpackage

// File: rtl/fir_sample_queue_if.sv
// fir_sample_queue_if: sample write/flush inputs and windowed read-out status of the queue.
interface fir_sample_queue_if import fir_queue_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NCH    = DEF_NCH
);
    logic                  wrt_smpl;
    logic                  clr;
    logic [NCH*DATA_W-1:0] smpl_in;
    logic [NCH*DATA_W-1:0] smpl_out;
    logic                  smpl_vld;
    logic                  sequencing;
    logic                  seq_done;
    logic                  full;
    logic                  overrun;
    modport master (output wrt_smpl, clr, smpl_in,
                    input smpl_out, smpl_vld, sequencing, seq_done, full, overrun);
    modport slave  (input wrt_smpl, clr, smpl_in,
                    output smpl_out, smpl_vld, sequencing, seq_done, full, overrun);
endinterface

// File: rtl/fir_sample_queue_ram.sv
// sample_ram: simple dual-port sample store with a registered read port and no reset.
module sample_ram import fir_queue_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int W      = DEF_NCH * DEF_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);
    logic [W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/fir_sample_queue.sv
// fir_sample_queue: circular sample buffer that replays the newest SEQ_LEN samples, oldest first, per trigger.
module fir_sample_queue import fir_queue_pkg::*; #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NCH     = DEF_NCH,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int SEQ_LEN = DEF_SEQ_LEN,
    parameter int DECIM   = DEF_DECIM
) (
    input logic               clk,
    input logic               rst_n,
    fir_sample_queue_if.slave bus
);
    localparam int W  = NCH * DATA_W;
    localparam int DW = DECIM > 1 ? $clog2(DECIM) : 1;
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] new_ptr, count, start, idx, raddr;
    logic [DW-1:0]     decim_cnt;
    logic [W-1:0]      rdata;
    logic              wr, win_rdy, trig, last, rd_vld, rd_last;
    assign wr             = bus.wrt_smpl && !bus.clr;
    assign win_rdy        = wr && (32'(count) + 1 >= SEQ_LEN);
    assign trig           = win_rdy && decim_cnt == '0;
    assign last           = state == SEQ && 32'(idx) == SEQ_LEN - 1;
    assign raddr          = start + idx;
    assign bus.full       = 32'(count) == SEQ_LEN;
    assign bus.sequencing = state == SEQ;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = bus.clr                  ? FILL :
                    (state == FILL && trig)  ? SEQ  :
                    last                     ? FILL : state;
    end
    // rd_vld/rd_last track the RAM read stage; the output stage adds one more register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_ptr      <= '0;
            count        <= '0;
            decim_cnt    <= '0;
            start        <= '0;
            idx          <= '0;
            rd_vld       <= 1'b0;
            rd_last      <= 1'b0;
            bus.smpl_out <= '0;
            bus.smpl_vld <= 1'b0;
            bus.seq_done <= 1'b0;
            bus.overrun  <= 1'b0;
        end else begin
            new_ptr      <= bus.clr ? '0 : new_ptr + ADDR_W'(wr);
            count        <= bus.clr ? '0 : (wr && !bus.full) ? count + 1'b1 : count;
            decim_cnt    <= bus.clr ? '0 : !win_rdy ? decim_cnt :
                            decim_cnt == DW'(DECIM - 1) ? '0 : decim_cnt + 1'b1;
            start        <= (state == FILL && trig) ? new_ptr + ADDR_W'(1) - ADDR_W'(SEQ_LEN) : start;
            idx          <= (state == SEQ && !last && !bus.clr) ? idx + 1'b1 : '0;
            rd_vld       <= state == SEQ && !bus.clr;
            rd_last      <= last && !bus.clr;
            bus.smpl_out <= (rd_vld && !bus.clr) ? rdata : '0;
            bus.smpl_vld <= rd_vld && !bus.clr;
            bus.seq_done <= rd_last && !bus.clr;
            bus.overrun  <= trig && state == SEQ;
        end
    end
    sample_ram #(.ADDR_W(ADDR_W), .W(W)) u_ram (
        .clk   (clk),
        .we    (wr),
        .waddr (new_ptr),
        .wdata (bus.smpl_in),
        .raddr (raddr),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_fir_sample_queue.sv
// tb_fir_sample_queue: directed checks of window replay, wrap, decimation, overrun, flush and reset.
module tb_fir_sample_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fir_sample_queue_if i0 ();
    fir_sample_queue_if i1 ();
    fir_sample_queue_if i2 ();

    fir_sample_queue u0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
    fir_sample_queue #(.ADDR_W(3), .SEQ_LEN(4), .DECIM(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
    fir_sample_queue #(.ADDR_W(3), .SEQ_LEN(4), .DECIM(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] got[$];
    int vld_step[$];
    logic [15:0] done_val[$];
    int ovr_n = 0;
    int ovr_step = -1;
    int zero_err = 0;
    logic last_full = 1'b0;

    // one clock: drive after the falling edge, sample the selected DUT after the next falling edge
    task automatic step(input int sel, input logic wr, input logic cl, input logic [15:0] v);
        logic [31:0] o;
        logic vld, dn, ov;
        i0.wrt_smpl = wr && sel == 0;
        i1.wrt_smpl = wr && sel == 1;
        i2.wrt_smpl = wr && sel == 2;
        i0.clr = cl && sel == 0;
        i1.clr = cl && sel == 1;
        i2.clr = cl && sel == 2;
        i0.smpl_in = {v + 16'd1000, v};
        i1.smpl_in = {v + 16'd1000, v};
        i2.smpl_in = {v + 16'd1000, v};
        @(posedge clk);
        @(negedge clk);
        cyc++;
        o   = sel == 0 ? i0.smpl_out : sel == 1 ? i1.smpl_out : i2.smpl_out;
        vld = sel == 0 ? i0.smpl_vld : sel == 1 ? i1.smpl_vld : i2.smpl_vld;
        dn  = sel == 0 ? i0.seq_done : sel == 1 ? i1.seq_done : i2.seq_done;
        ov  = sel == 0 ? i0.overrun  : sel == 1 ? i1.overrun  : i2.overrun;
        last_full = sel == 0 ? i0.full : sel == 1 ? i1.full : i2.full;
        if (vld) begin
            got.push_back(o);
            vld_step.push_back(cyc);
        end else if (o !== '0) zero_err++;
        if (dn) done_val.push_back(o[15:0]);
        if (ov) begin
            ovr_n++;
            ovr_step = cyc;
        end
    endtask

    task automatic idle(input int sel, input int n);
        for (int k = 0; k < n; k++) step(sel, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic clear_obs();
        got.delete();
        vld_step.delete();
        done_val.delete();
        ovr_n = 0;
        ovr_step = -1;
        zero_err = 0;
    endtask

    // number of entries deviating from the window lo..lo+n-1 (size mismatch counts once)
    function automatic int win_bad(input int lo, input int n);
        int b;
        b = (got.size() != n) ? 1 : 0;
        for (int i = 0; i < got.size() && i < n; i++)
            if (got[i] !== {16'(lo + i + 1000), 16'(lo + i)}) b++;
        return b;
    endfunction

    task automatic test_reset();
        i0.wrt_smpl = 0; i1.wrt_smpl = 0; i2.wrt_smpl = 0;
        i0.clr = 0; i1.clr = 0; i2.clr = 0;
        i0.smpl_in = '0; i1.smpl_in = '0; i2.smpl_in = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({i0.smpl_out, i0.smpl_vld, i0.sequencing, i0.seq_done, i0.full, i0.overrun} !== '0) begin
            failures++;
            $display("FAIL reset_u0 outputs=%h want 0", {i0.smpl_out, i0.smpl_vld, i0.sequencing, i0.seq_done, i0.full, i0.overrun});
        end
        checks++;
        if ({i1.smpl_out, i1.smpl_vld, i1.sequencing, i1.seq_done, i1.full, i1.overrun} !== '0) begin
            failures++;
            $display("FAIL reset_u1 outputs=%h want 0", {i1.smpl_out, i1.smpl_vld, i1.sequencing, i1.seq_done, i1.full, i1.overrun});
        end
        checks++;
        if ({i2.smpl_out, i2.smpl_vld, i2.sequencing, i2.seq_done, i2.full, i2.overrun} !== '0) begin
            failures++;
            $display("FAIL reset_u2 outputs=%h want 0", {i2.smpl_out, i2.smpl_vld, i2.sequencing, i2.seq_done, i2.full, i2.overrun});
        end
        rst_n = 1'b1;
        idle(1, 2);
        checks++;
        if ({i1.smpl_vld, i1.sequencing, i1.full, i1.overrun} !== 4'b0) begin
            failures++;
            $display("FAIL post_reset_idle flags=%b want 0000", {i1.smpl_vld, i1.sequencing, i1.full, i1.overrun});
        end
    endtask

    task automatic test_full_window();
        int trig, span;
        clear_obs();
        trig = 0;
        for (int n = 1; n <= 1021; n++) begin
            step(0, 1'b1, 1'b0, 16'(n));
            if (n == 1020) begin
                checks++;
                if (last_full !== 1'b0) begin
                    failures++;
                    $display("FAIL full_early full=%b want 0", last_full);
                end
            end
            if (n == 1021) begin
                trig = cyc;
                checks++;
                if (last_full !== 1'b1) begin
                    failures++;
                    $display("FAIL full_set full=%b want 1", last_full);
                end
            end
        end
        for (int k = 0; k < 1030 && done_val.size() == 0; k++) idle(0, 1);
        idle(0, 2);
        checks++;
        if (done_val.size() !== 1) begin
            failures++;
            $display("FAIL long_done count=%0d want 1", done_val.size());
        end else begin
            checks++;
            if (done_val[0] !== 16'd1021) begin
                failures++;
                $display("FAIL long_done_val got=%0d want 1021", done_val[0]);
            end
        end
        checks++;
        if (win_bad(1, 1021) !== 0) begin
            failures++;
            $display("FAIL long_window bad=%0d size=%0d want size 1021", win_bad(1, 1021), got.size());
        end
        span = vld_step.size() > 0 ? vld_step[vld_step.size() - 1] - vld_step[0] : -1;
        checks++;
        if (vld_step.size() == 0 || vld_step[0] !== trig + 2 || span !== 1020) begin
            failures++;
            $display("FAIL long_timing first=%0d want %0d span=%0d want 1020",
                     vld_step.size() > 0 ? vld_step[0] : -1, trig + 2, span);
        end
        checks++;
        if (zero_err !== 0) begin
            failures++;
            $display("FAIL long_idle_zero nonzero_cycles=%0d want 0", zero_err);
        end
    endtask

    task automatic test_wrap();
        int bad;
        for (int n = 1; n <= 12; n++) begin
            clear_obs();
            step(1, 1'b1, 1'b0, 16'(n));
            idle(1, 7);
            bad = n >= 4 ? win_bad(n - 3, 4) + (done_val.size() != 1 ? 1 : 0) : got.size();
            checks++;
            if (bad !== 0) begin
                failures++;
                $display("FAIL wrap_write%0d bad=%0d size=%0d first=%h", n, bad, got.size(),
                         got.size() > 0 ? got[0] : 32'h0);
            end
        end
    endtask

    task automatic test_decim();
        int bad;
        for (int n = 1; n <= 8; n++) begin
            clear_obs();
            step(2, 1'b1, 1'b0, 16'(n));
            idle(2, 7);
            bad = (n >= 4 && n % 2 == 0) ? win_bad(n - 3, 4) : got.size();
            checks++;
            if (bad !== 0) begin
                failures++;
                $display("FAIL decim_write%0d bad=%0d size=%0d", n, bad, got.size());
            end
        end
    endtask

    task automatic test_overrun();
        int t;
        step(1, 1'b0, 1'b1, 16'd0);
        for (int n = 30; n <= 32; n++) begin
            step(1, 1'b1, 1'b0, 16'(n));
            idle(1, 2);
        end
        clear_obs();
        step(1, 1'b1, 1'b0, 16'd33);
        t = cyc;
        step(1, 1'b1, 1'b0, 16'd34);
        idle(1, 8);
        checks++;
        if (win_bad(30, 4) !== 0) begin
            failures++;
            $display("FAIL overrun_window bad=%0d size=%0d want 4", win_bad(30, 4), got.size());
        end
        checks++;
        if (ovr_n !== 1) begin
            failures++;
            $display("FAIL overrun_count got=%0d want 1", ovr_n);
        end
        checks++;
        if (ovr_step !== t + 1) begin
            failures++;
            $display("FAIL overrun_timing got=%0d want %0d", ovr_step, t + 1);
        end
        checks++;
        if (done_val.size() !== 1) begin
            failures++;
            $display("FAIL overrun_done count=%0d want 1", done_val.size());
        end
    endtask

    task automatic test_clr();
        step(1, 1'b0, 1'b1, 16'd0);
        for (int n = 40; n <= 42; n++) begin
            step(1, 1'b1, 1'b0, 16'(n));
            idle(1, 2);
        end
        clear_obs();
        step(1, 1'b1, 1'b0, 16'd43);
        idle(1, 2);
        step(1, 1'b1, 1'b1, 16'd99);
        idle(1, 6);
        checks++;
        if (win_bad(40, 1) !== 0) begin
            failures++;
            $display("FAIL clr_cut size=%0d want 1", got.size());
        end
        checks++;
        if (last_full !== 1'b0) begin
            failures++;
            $display("FAIL clr_full full=%b want 0", last_full);
        end
        clear_obs();
        for (int n = 20; n <= 23; n++) begin
            step(1, 1'b1, 1'b0, 16'(n));
            idle(1, 7);
        end
        checks++;
        if (win_bad(20, 4) !== 0) begin
            failures++;
            $display("FAIL clr_refill bad=%0d size=%0d first=%h", win_bad(20, 4), got.size(),
                     got.size() > 0 ? got[0] : 32'h0);
        end
        checks++;
        if (done_val.size() !== 1 || done_val[0] !== 16'd23) begin
            failures++;
            $display("FAIL clr_refill_done count=%0d want 1 (value 23)", done_val.size());
        end
    endtask

    task automatic test_rst_mid();
        step(1, 1'b0, 1'b1, 16'd0);
        for (int n = 50; n <= 52; n++) begin
            step(1, 1'b1, 1'b0, 16'(n));
            idle(1, 2);
        end
        step(1, 1'b1, 1'b0, 16'd53);
        idle(1, 2);
        clear_obs();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({i1.smpl_out, i1.smpl_vld, i1.sequencing, i1.seq_done, i1.full, i1.overrun} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%h want 0", {i1.smpl_out, i1.smpl_vld, i1.sequencing, i1.seq_done, i1.full, i1.overrun});
        end
        @(negedge clk);
        idle(1, 2);
        rst_n = 1'b1;
        for (int n = 60; n <= 62; n++) begin
            step(1, 1'b1, 1'b0, 16'(n));
            idle(1, 7);
        end
        checks++;
        if (got.size() !== 0) begin
            failures++;
            $display("FAIL rst_mid_quiet vld_count=%0d want 0", got.size());
        end
        step(1, 1'b1, 1'b0, 16'd63);
        checks++;
        if (last_full !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_full full=%b want 1", last_full);
        end
        idle(1, 7);
        checks++;
        if (win_bad(60, 4) !== 0) begin
            failures++;
            $display("FAIL rst_mid_refill bad=%0d size=%0d", win_bad(60, 4), got.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_wrap();
        test_decim();
        test_overrun();
        test_clr();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
